// File: rtl/sub_op_serial_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Purpose : Shared types and constants for the 4-bit processor datapath.
//           Holds the FSM state type of the bit-serial subtractor and
//           default operand widths.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package proc_pkg;

   // States of the bit-serial subtractor: waiting, one bit per cycle, result pulse
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sub_state_t;

   localparam int PROC_WIDTH     = 4;
   localparam int PROC_SUB_WIDTH = 2;

   // Width of a counter that can index every bit of a WIDTH-bit word.
   // A 1-bit word still needs a 1-bit counter so the register never vanishes.
   function automatic int idxWidth(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/sub_op_serial_if.sv
// -----------------------------------------------------------------------------
// sub_op_serial_if
// Purpose : Request/response bundle between the ALU sequencer and the
//           bit-serial subtractor.
// Signals : start  - request, honoured only while the subtractor is idle
//           num1   - subtrahend (SUB_WIDTH bits, zero-extended inside)
//           num2   - minuend (WIDTH bits)
//           busy   - operation in flight (bit shifting or result pulse)
//           done   - one-cycle pulse, result is valid
//           result - {borrow, difference[WIDTH-1:0]}
// Modports: master drives the request side, slave is the subtractor.
// -----------------------------------------------------------------------------
interface sub_op_serial_if
   import proc_pkg::*;
#(
   parameter int WIDTH     = PROC_WIDTH,
   parameter int SUB_WIDTH = PROC_SUB_WIDTH
);

   logic                 start;
   logic [SUB_WIDTH-1:0] num1;
   logic [WIDTH-1:0]     num2;
   logic                 busy;
   logic                 done;
   logic [WIDTH:0]       result;

   modport master (
      output start,
      output num1,
      output num2,
      input  busy,
      input  done,
      input  result
   );

   modport slave (
      input  start,
      input  num1,
      input  num2,
      output busy,
      output done,
      output result
   );

endinterface

// File: rtl/sub_op_serial_full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Purpose : One-bit full subtractor computing a - b - bin.
// Ports   : a_i    - minuend bit
//           b_i    - subtrahend bit
//           bin_i  - borrow in from the lower bit
//           d_o    - difference bit
//           bout_o - borrow out to the next higher bit
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic bin_i,
   output logic d_o,
   output logic bout_o
);

   // A borrow is produced when b exceeds a outright, or when a and b are equal
   // and a borrow is already coming in from below.
   always_comb begin
      d_o    = a_i ^ b_i ^ bin_i;
      bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);
   end

endmodule

// File: rtl/sub_op_serial.sv
// -----------------------------------------------------------------------------
// sub_op_serial
// Purpose : Bit-serial subtractor, result = num2 - zext(num1), one bit per
//           clock, LSB first, with a borrow (underflow) flag in result[WIDTH].
//           Serves the SUB path of the 4-bit processor ALU.
// Ports   : clk  - single clock, rising edge
//           rst  - synchronous, active-high reset
//           bus  - sub_op_serial_if.slave (start/num1/num2 in,
//                  busy/done/result out)
// Params  : WIDTH     - minuend and difference width
//           SUB_WIDTH - subtrahend width, must not exceed WIDTH
// Config  : SUB_OP_SAT_EN - when defined, an underflowing difference is
//           floored at zero while the borrow flag is still reported.
//           Undefined (default) keeps the wrapped two's-complement value.
// -----------------------------------------------------------------------------
module sub_op_serial
   import proc_pkg::*;
#(
   parameter int WIDTH     = PROC_WIDTH,
   parameter int SUB_WIDTH = PROC_SUB_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   sub_op_serial_if.slave    bus
);

   localparam int IDX_W = idxWidth(WIDTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

   sub_state_t       state_q,   state_d;
   logic [WIDTH-1:0] minuend_q, minuend_d;
   logic [WIDTH-1:0] subtr_q,   subtr_d;
   logic [WIDTH-1:0] diff_q,    diff_d;
   logic [IDX_W-1:0] bitIdx_q,  bitIdx_d;
   logic             borrow_q,  borrow_d;
   logic [WIDTH:0]   result_q,  result_d;

   logic             fsDiff;
   logic             fsBorrow;

   // The single full subtractor always looks at the bit selected by the
   // counter; its outputs are only consumed while shifting.
   full_subtractor u_fullSub (
      .a_i    (minuend_q[bitIdx_q]),
      .b_i    (subtr_q[bitIdx_q]),
      .bin_i  (borrow_q),
      .d_o    (fsDiff),
      .bout_o (fsBorrow)
   );

   // Next-state and datapath control. Operands are captured on an accepted
   // start so the requester may change its inputs immediately afterwards.
   // The visible result is written only on the edge that enters DONE, which
   // keeps it stable for the whole operation and until the next one ends.
   // Start requests arriving while shifting or in DONE are simply dropped.
   always_comb begin
      state_d   = state_q;
      minuend_d = minuend_q;
      subtr_d   = subtr_q;
      diff_d    = diff_q;
      bitIdx_d  = bitIdx_q;
      borrow_d  = borrow_q;
      result_d  = result_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = SHIFT;
               minuend_d = bus.num2;
               subtr_d   = WIDTH'(bus.num1);
               diff_d    = '0;
               bitIdx_d  = '0;
               borrow_d  = 1'b0;
            end
         end

         SHIFT: begin
            diff_d[bitIdx_q] = fsDiff;
            borrow_d         = fsBorrow;
            bitIdx_d         = bitIdx_q + IDX_W'(1);
            if (bitIdx_q == LAST_IDX) begin
               state_d = DONE;
`ifdef SUB_OP_SAT_EN
               result_d = fsBorrow ? {1'b1, {WIDTH{1'b0}}} : {1'b0, diff_d};
`else
               result_d = {fsBorrow, diff_d};
`endif
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset aborts any operation in progress
   // and clears everything, including the held result; it also overrides a
   // start request presented in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         minuend_q <= '0;
         subtr_q   <= '0;
         diff_q    <= '0;
         bitIdx_q  <= '0;
         borrow_q  <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         minuend_q <= minuend_d;
         subtr_q   <= subtr_d;
         diff_q    <= diff_d;
         bitIdx_q  <= bitIdx_d;
         borrow_q  <= borrow_d;
         result_q  <= result_d;
      end
   end

   // Handshake outputs are pure decodes of the state register.
   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;

endmodule

// File: tb/tb_sub_op_serial.sv
// -----------------------------------------------------------------------------
// tb_sub_op_serial
// Purpose : Self-checking bench for sub_op_serial. Expected results and their
//           completion cycles are queued when an operation is launched and
//           checked when the design pulses done.
// -----------------------------------------------------------------------------
module tb_sub_op_serial;
   import proc_pkg::*;

   localparam int WIDTH     = PROC_WIDTH;
   localparam int SUB_WIDTH = 2;

   typedef struct {
      logic [WIDTH:0] res;
      int             doneCycle;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cycle       = 0;
   int   testsRun    = 0;
   int   testsFailed = 0;
   exp_t sb[$];

   sub_op_serial_if #(.WIDTH(WIDTH), .SUB_WIDTH(SUB_WIDTH)) bus ();

   sub_op_serial #(.WIDTH(WIDTH), .SUB_WIDTH(SUB_WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock and a cycle counter used to check done latency
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Reference: plain wide subtraction, borrow falls out of the top bit
   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] n2,
                                            input logic [SUB_WIDTH-1:0] n1);
      logic [WIDTH:0] full;
      full = {1'b0, n2} - {1'b0, WIDTH'(n1)};
`ifdef SUB_OP_SAT_EN
      if (full[WIDTH]) full[WIDTH-1:0] = '0;
`endif
      return full;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Launch one request from a negedge; queue its expectation when it should
   // complete. Returns one cycle later with busy checked.
   task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] n2,
                                input logic [SUB_WIDTH-1:0] n1, input bit expectDone);
      bus.start = 1'b1;
      bus.num2  = n2;
      bus.num1  = n1;
      if (expectDone) sb.push_back('{res: model(n2, n1), doneCycle: cycle + WIDTH + 1});
      @(negedge clk);
      bus.start = 1'b0;
      bus.num2  = $urandom_range(0, 15);
      bus.num1  = $urandom_range(0, 3);
      checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
   endtask

   // Wait (bounded) until every queued result has been seen, then settle in IDLE
   task automatic waitDrain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_drain"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
   endtask

   // Completion monitor: every done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            checkOutput("spurious_done", 32'(bus.done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("result", 32'(bus.result), 32'(e.res));
            checkOutput("latency", 32'(cycle), 32'(e.doneCycle));
            checkOutput("busy_in_done", 32'(bus.busy), 32'd1);
         end
      end
   end

   // Global watchdog so the run always ends
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.num1  = '0;
      bus.num2  = '0;
      repeat (2) @(negedge clk);

      // Reset state
      checkOutput("reset_busy",   32'(bus.busy),   32'd0);
      checkOutput("reset_done",   32'(bus.done),   32'd0);
      checkOutput("reset_result", 32'(bus.result), 32'd0);

      // Reset wins over a simultaneous start
      bus.start = 1'b1;
      bus.num2  = 4'd9;
      bus.num1  = 2'd2;
      @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      checkOutput("rst_over_start_busy", 32'(bus.busy), 32'd0);

      // 9 - 2 = 7
      applyStimulus("t1", 4'd9, 2'd2, 1'b1);
      waitDrain("t1");
      checkOutput("t1_hold", 32'(bus.result), 32'(model(4'd9, 2'd2)));
      checkOutput("t1_idle", 32'(bus.busy), 32'd0);

      // 1 - 3 underflows (wraps to 14 with borrow, or floors at zero)
      applyStimulus("t2", 4'd1, 2'd3, 1'b1);
      waitDrain("t2");

      // Boundaries: largest minuend, zero minus zero, equal operands
      applyStimulus("t3a", 4'd15, 2'd3, 1'b1);
      waitDrain("t3a");
      applyStimulus("t3b", 4'd0, 2'd0, 1'b1);
      waitDrain("t3b");
      applyStimulus("t3c", 4'd3, 2'd3, 1'b1);
      waitDrain("t3c");

      // Start pulsed mid-operation with new operands is ignored
      applyStimulus("t4", 4'd9, 2'd2, 1'b1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.num2  = 4'd1;
      bus.num1  = 2'd3;
      @(negedge clk);
      bus.start = 1'b0;
      waitDrain("t4");
      repeat (8) @(negedge clk);
      checkOutput("t4_result_kept", 32'(bus.result), 32'(model(4'd9, 2'd2)));

      // Reset mid-operation aborts with no done pulse and clears the result
      applyStimulus("t5", 4'd15, 2'd3, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("t5_busy",   32'(bus.busy),   32'd0);
      checkOutput("t5_done",   32'(bus.done),   32'd0);
      checkOutput("t5_result", 32'(bus.result), 32'd0);
      repeat (8) @(negedge clk);
      checkOutput("t5_result_still0", 32'(bus.result), 32'd0);
      applyStimulus("t5_after", 4'd6, 2'd1, 1'b1);
      waitDrain("t5_after");

      // Start held high for 20 cycles: a new op every WIDTH+2 cycles
      bus.start = 1'b1;
      bus.num2  = 4'd6;
      bus.num1  = 2'd1;
      for (int i = 0; i < 20; i++) begin
         if (i % (WIDTH + 2) == 0)
            sb.push_back('{res: model(4'd6, 2'd1), doneCycle: cycle + WIDTH + 1});
         @(negedge clk);
      end
      bus.start = 1'b0;
      waitDrain("t6");
      repeat (8) @(negedge clk);
      checkOutput("t6_idle", 32'(bus.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
